// File: rtl/multicycle_ctrl_if.sv
// Shared memory-port handshake between the multicycle controller and its memory.
// A request is held with mem_req=1 until the first cycle mem_ready=1; that cycle
// is the transfer (fetch data valid, load data valid, or store accepted).
interface multicycle_ctrl_if;
  logic mem_req;
  logic mem_we;
  logic mem_ifetch;
  logic mem_ready;

  modport master (output mem_req, output mem_we, output mem_ifetch, input mem_ready);
  modport slave  (input mem_req, input mem_we, input mem_ifetch, output mem_ready);
endinterface

// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I-subset control FSM: FETCH/DECODE/EXEC/MEM/WB with memory stall and trap.
// Optional PERF_CNT_EN adds cycle_cnt/instret_cnt performance counters.
module multicycle_ctrl #(
  parameter int unsigned WAIT_LIMIT = 16,
  parameter logic [31:0] PC_RESET   = 32'h0000_0000
) (
  input  logic                clk,
  input  logic                rst,
  multicycle_ctrl_if.master   mem,
  input  logic [31:0]         inst_field,
  input  logic [31:0]         pc_in,
  input  logic                zero,
  output logic                IRWrite,
  output logic                PCWrite,
  output logic [2:0]          ALU_Control,
  output logic [1:0]          ImmSel,
  output logic [1:0]          MemtoReg,
  output logic                ALUSrc_B,
  output logic                Jump,
  output logic                Branch,
  output logic                RegWrite,
  output logic                trap,
  output logic [1:0]          trap_cause,
  output logic [31:0]         trap_pc,
  output logic [2:0]          state_dbg
`ifdef PERF_CNT_EN
  ,
  output logic [31:0]         cycle_cnt,
  output logic [31:0]         instret_cnt
`endif
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_t;

  typedef enum logic [2:0] {K_ILL, K_R, K_I, K_LW, K_SW, K_BEQ, K_JAL} kind_t;

  localparam int CW = (WAIT_LIMIT > 1) ? $clog2(WAIT_LIMIT) : 1;
  localparam logic [CW-1:0] WAIT_LAST = CW'(WAIT_LIMIT - 1);
  localparam bit LIMIT_EN = (WAIT_LIMIT != 0);

  state_t        state;
  logic [CW-1:0] wait_cnt;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       rd_nz;
  kind_t      kind;
  logic [2:0] alu_op;
  logic [1:0] imm_sel;
  logic       src_b;
  logic       timeout;

  logic mem_req, mem_we, mem_ifetch;

  // The controller never looks at rs1/rs2 or the zero flag; the datapath uses them.
  logic unused_bits;
  assign unused_bits = ^{zero, inst_field[24:15]};

  assign opcode = inst_field[6:0];
  assign funct3 = inst_field[14:12];
  assign funct7 = inst_field[31:25];
  assign rd_nz  = (inst_field[11:7] != 5'd0);

  always_comb begin
    kind    = K_ILL;
    alu_op  = 3'b010;
    imm_sel = 2'b00;
    src_b   = 1'b0;
    case (opcode)
      7'b0110011: begin
        if (funct7 == 7'b0000000) begin
          kind = K_R;
          case (funct3)
            3'b000:  alu_op = 3'b010;
            3'b111:  alu_op = 3'b000;
            3'b110:  alu_op = 3'b001;
            3'b100:  alu_op = 3'b011;
            3'b101:  alu_op = 3'b101;
            3'b010:  alu_op = 3'b111;
            default: kind   = K_ILL;
          endcase
        end else if (funct7 == 7'b0100000 && funct3 == 3'b000) begin
          kind   = K_R;
          alu_op = 3'b110;
        end
      end
      7'b0010011: begin
        kind  = K_I;
        src_b = 1'b1;
        case (funct3)
          3'b000:  alu_op = 3'b010;
          3'b111:  alu_op = 3'b000;
          3'b110:  alu_op = 3'b001;
          3'b100:  alu_op = 3'b011;
          3'b010:  alu_op = 3'b111;
          default: kind   = K_ILL;
        endcase
      end
      7'b0000011: if (funct3 == 3'b010) begin kind = K_LW; src_b = 1'b1; end
      7'b0100011: if (funct3 == 3'b010) begin kind = K_SW; src_b = 1'b1; imm_sel = 2'b01; end
      7'b1100011: if (funct3 == 3'b000) begin kind = K_BEQ; alu_op = 3'b110; imm_sel = 2'b10; end
      7'b1101111: begin kind = K_JAL; imm_sel = 2'b11; end
      default: kind = K_ILL;
    endcase
  end

  // Fires on the last allowed stall cycle, so the request is held exactly WAIT_LIMIT cycles.
  assign timeout = LIMIT_EN && !mem.mem_ready && (wait_cnt == WAIT_LAST);

  always_comb begin
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    mem_ifetch  = 1'b0;
    IRWrite     = 1'b0;
    PCWrite     = 1'b0;
    ALU_Control = 3'b000;
    ImmSel      = 2'b00;
    MemtoReg    = 2'b00;
    ALUSrc_B    = 1'b0;
    Jump        = 1'b0;
    Branch      = 1'b0;
    RegWrite    = 1'b0;
    if (!rst) begin
      case (state)
        S_FETCH: begin
          mem_req    = 1'b1;
          mem_ifetch = 1'b1;
          IRWrite    = mem.mem_ready;
        end
        S_EXEC: begin
          ALU_Control = alu_op;
          ImmSel      = imm_sel;
          ALUSrc_B    = src_b;
          if (kind == K_BEQ) begin
            Branch  = 1'b1;
            PCWrite = 1'b1;
          end else if (kind == K_JAL) begin
            Jump     = 1'b1;
            MemtoReg = 2'b10;
            RegWrite = rd_nz;
            PCWrite  = 1'b1;
          end
        end
        S_MEM: begin
          mem_req     = 1'b1;
          mem_we      = (kind == K_SW);
          ALU_Control = alu_op;
          ImmSel      = imm_sel;
          ALUSrc_B    = src_b;
          PCWrite     = (kind == K_SW) && mem.mem_ready;
        end
        S_WB: begin
          ALU_Control = alu_op;
          ImmSel      = imm_sel;
          ALUSrc_B    = src_b;
          MemtoReg    = (kind == K_LW) ? 2'b01 : 2'b00;
          RegWrite    = rd_nz;
          PCWrite     = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign mem.mem_req    = mem_req;
  assign mem.mem_we     = mem_we;
  assign mem.mem_ifetch = mem_ifetch;
  assign state_dbg      = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_FETCH;
      wait_cnt   <= '0;
      trap       <= 1'b0;
      trap_cause <= 2'b00;
      trap_pc    <= PC_RESET;
    end else begin
      wait_cnt <= '0;
      case (state)
        S_FETCH, S_MEM: begin
          if (mem.mem_ready) begin
            if (state == S_FETCH)    state <= S_DECODE;
            else if (kind == K_LW)   state <= S_WB;
            else                     state <= S_FETCH;
          end else if (timeout) begin
            state      <= S_TRAP;
            trap       <= 1'b1;
            trap_cause <= 2'b10;
            trap_pc    <= pc_in;
          end else begin
            wait_cnt <= wait_cnt + CW'(1);
          end
        end
        S_DECODE: begin
          if (kind == K_ILL) begin
            state      <= S_TRAP;
            trap       <= 1'b1;
            trap_cause <= 2'b01;
            trap_pc    <= pc_in;
          end else begin
            state <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (kind == K_R || kind == K_I)        state <= S_WB;
          else if (kind == K_LW || kind == K_SW) state <= S_MEM;
          else                                   state <= S_FETCH;
        end
        S_WB:    state <= S_FETCH;
        S_TRAP:  state <= S_TRAP;
        default: state <= S_FETCH;
      endcase
    end
  end

`ifdef PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_cnt   <= 32'd0;
      instret_cnt <= 32'd0;
    end else begin
      if (state != S_TRAP) cycle_cnt <= cycle_cnt + 32'd1;
      if (PCWrite)         instret_cnt <= instret_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: instruction sequences, memory stalls, traps, reset.
module tb_multicycle_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] inst_field = 32'd0;
  logic [31:0] pc_in = 32'd0;
  logic        zero = 1'b0;
  logic        IRWrite, PCWrite, ALUSrc_B, Jump, Branch, RegWrite, trap;
  logic [2:0]  ALU_Control, state_dbg;
  logic [1:0]  ImmSel, MemtoReg, trap_cause;
  logic [31:0] trap_pc;
`ifdef PERF_CNT_EN
  logic [31:0] cycle_cnt, instret_cnt;
`endif

  int pass_cnt = 0;
  int fail_cnt = 0;
  int total_cnt = 0;

  multicycle_ctrl_if mem_bus();

  always #5 clk = ~clk;

  multicycle_ctrl #(.WAIT_LIMIT(16), .PC_RESET(32'h0000_0000)) dut (
    .clk(clk), .rst(rst), .mem(mem_bus),
    .inst_field(inst_field), .pc_in(pc_in), .zero(zero),
    .IRWrite(IRWrite), .PCWrite(PCWrite), .ALU_Control(ALU_Control),
    .ImmSel(ImmSel), .MemtoReg(MemtoReg), .ALUSrc_B(ALUSrc_B),
    .Jump(Jump), .Branch(Branch), .RegWrite(RegWrite),
    .trap(trap), .trap_cause(trap_cause), .trap_pc(trap_pc),
    .state_dbg(state_dbg)
`ifdef PERF_CNT_EN
    , .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // {mem_req, mem_we, mem_ifetch, IRWrite, PCWrite, RegWrite, Branch, Jump}
  function automatic logic [7:0] strobes();
    return {mem_bus.mem_req, mem_bus.mem_we, mem_bus.mem_ifetch, IRWrite,
            PCWrite, RegWrite, Branch, Jump};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic step(input string tag, input logic [2:0] st, input logic [7:0] sb);
    #1;
    check({tag, ".state"}, 32'(state_dbg), 32'(st));
    check({tag, ".strobes"}, 32'(strobes()), 32'(sb));
  endtask

  // Full R/I-type instruction with zero-wait memory, starting in a FETCH cycle.
  task automatic run_alu(input string tag, input logic [31:0] inst,
                         input logic [2:0] alu, input logic srcb);
    inst_field = inst;
    step({tag, ".fetch"}, 3'd0, 8'hB0);
    tick; step({tag, ".decode"}, 3'd1, 8'h00);
    tick; step({tag, ".exec"}, 3'd2, 8'h00);
    check({tag, ".alu"}, 32'(ALU_Control), 32'(alu));
    check({tag, ".srcb"}, 32'(ALUSrc_B), 32'(srcb));
    tick; step({tag, ".wb"}, 3'd4, 8'h0C);
    check({tag, ".m2r"}, 32'(MemtoReg), 32'd0);
    tick;
  endtask

  initial begin
    mem_bus.mem_ready = 1'b1;
    rst = 1'b1;
    tick; tick;
    step("reset", 3'd0, 8'h00);
    check("reset.trap", 32'(trap), 32'd0);
    check("reset.cause", 32'(trap_cause), 32'd0);
    check("reset.trap_pc", trap_pc, 32'h0);
    rst = 1'b0;

    // ADD x3,x1,x2: 0,1,2,4,0
    run_alu("add", 32'h002081B3, 3'b010, 1'b0);
`ifdef PERF_CNT_EN
    check("perf.instret", instret_cnt, 32'd1);
    check("perf.cycle", cycle_cnt, 32'd4);
`endif

    // LW x5,8(x1) with three stall cycles in MEM
    inst_field = 32'h0080A283;
    step("lw.fetch", 3'd0, 8'hB0);
    tick; step("lw.decode", 3'd1, 8'h00);
    tick; step("lw.exec", 3'd2, 8'h00);
    check("lw.alu", 32'(ALU_Control), 32'b010);
    check("lw.srcb", 32'(ALUSrc_B), 32'd1);
    check("lw.imm", 32'(ImmSel), 32'd0);
    tick; mem_bus.mem_ready = 1'b0;
    step("lw.mem0", 3'd3, 8'h80);
    tick; step("lw.mem1", 3'd3, 8'h80);
    tick; step("lw.mem2", 3'd3, 8'h80);
    tick; mem_bus.mem_ready = 1'b1;
    step("lw.mem3", 3'd3, 8'h80);
    check("lw.mem3.srcb", 32'(ALUSrc_B), 32'd1);
    tick; step("lw.wb", 3'd4, 8'h0C);
    check("lw.m2r", 32'(MemtoReg), 32'd1);
    tick;

    // SW x2,4(x1) with one stall cycle
    inst_field = 32'h0020A223;
    step("sw.fetch", 3'd0, 8'hB0);
    tick; step("sw.decode", 3'd1, 8'h00);
    tick; step("sw.exec", 3'd2, 8'h00);
    check("sw.imm", 32'(ImmSel), 32'd1);
    tick; mem_bus.mem_ready = 1'b0;
    step("sw.memwait", 3'd3, 8'hC0);
    tick; mem_bus.mem_ready = 1'b1;
    step("sw.mem", 3'd3, 8'hC8);
    tick;

    // BEQ with zero=1 then zero=0: identical control, 3 cycles each
    for (int i = 0; i < 2; i++) begin
      zero = (i == 0);
      inst_field = 32'h00208063;
      step("beq.fetch", 3'd0, 8'hB0);
      tick; step("beq.decode", 3'd1, 8'h00);
      tick; step("beq.exec", 3'd2, 8'h0A);
      check("beq.alu", 32'(ALU_Control), 32'b110);
      check("beq.imm", 32'(ImmSel), 32'd2);
      tick;
    end

    // JAL x0 then JAL x1
    for (int i = 0; i < 2; i++) begin
      inst_field = (i == 0) ? 32'h0000006F : 32'h000000EF;
      step("jal.fetch", 3'd0, 8'hB0);
      tick; step("jal.decode", 3'd1, 8'h00);
      tick; step("jal.exec", 3'd2, (i == 0) ? 8'h09 : 8'h0D);
      check("jal.m2r", 32'(MemtoReg), 32'd2);
      check("jal.imm", 32'(ImmSel), 32'd3);
      tick;
    end

    run_alu("addi", 32'h00500093, 3'b010, 1'b1);
    run_alu("sub",  32'h402081B3, 3'b110, 1'b0);
    run_alu("slt",  32'h0020A1B3, 3'b111, 1'b0);
    run_alu("xori", 32'h0040C093, 3'b011, 1'b1);
    check("after.state", 32'(state_dbg), 32'd0);

    // Reset during WB: no commit strobes, then FETCH
    inst_field = 32'h002081B3;
    step("rmid.fetch", 3'd0, 8'hB0);
    tick; tick; tick;
    rst = 1'b1;
    step("rmid.wb", 3'd4, 8'h00);
    tick; rst = 1'b0;
    step("rmid.after", 3'd0, 8'hB0);

    // Illegal instruction at 0x40
    inst_field = 32'hFFFF_FFFF;
    pc_in = 32'h40;
    tick; step("ill.decode", 3'd1, 8'h00);
    tick; pc_in = 32'h80;
    step("ill.trap", 3'd5, 8'h00);
    check("ill.flag", 32'(trap), 32'd1);
    check("ill.cause", 32'(trap_cause), 32'd1);
    check("ill.pc", trap_pc, 32'h40);
    mem_bus.mem_ready = 1'b0;
    tick; step("ill.hold0", 3'd5, 8'h00);
    mem_bus.mem_ready = 1'b1;
    tick; step("ill.hold1", 3'd5, 8'h00);
    check("ill.pc_hold", trap_pc, 32'h40);
    rst = 1'b1;
    tick; rst = 1'b0;
    step("ill.reset", 3'd0, 8'hB0);
    check("ill.reset.trap", 32'(trap), 32'd0);
    check("ill.reset.pc", trap_pc, 32'h0);

    // Illegal funct7/funct3 combination in an R-type
    inst_field = 32'h4020F1B3;
    pc_in = 32'h24;
    tick; step("illr.decode", 3'd1, 8'h00);
    tick; step("illr.trap", 3'd5, 8'h00);
    check("illr.cause", 32'(trap_cause), 32'd1);
    check("illr.pc", trap_pc, 32'h24);
    rst = 1'b1;
    tick; rst = 1'b0;

    // Fetch timeout: 16 stalled request cycles, then TRAP
    mem_bus.mem_ready = 1'b0;
    pc_in = 32'h100;
    for (int i = 0; i < 16; i++) begin
      step("tmo.wait", 3'd0, 8'hA0);
      tick;
    end
    step("tmo.trap", 3'd5, 8'h00);
    check("tmo.flag", 32'(trap), 32'd1);
    check("tmo.cause", 32'(trap_cause), 32'd2);
    check("tmo.pc", trap_pc, 32'h100);
    rst = 1'b1;
    tick; rst = 1'b0;
    step("tmo.reset", 3'd0, 8'hA0);
    check("tmo.reset.trap", 32'(trap), 32'd0);
    check("tmo.reset.cause", 32'(trap_cause), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
Multi-cycle control FSM that sequences the RV32I-subset datapath: PC, register file, immediate generator, ALU and a shared memory port. Replaces fixed single-cycle control by stepping each instruction through FETCH/DECODE/EXEC/MEM/WB. Issues memory requests with a ready handshake, so slow memories stall the core cleanly. Traps on illegal instructions or memory timeout.

Parameters:
WAIT_LIMIT, 16, max cycles a memory request may wait for mem_ready before trap; 0 = wait forever
PC_RESET, 32'h0000_0000, value reported on trap_pc after reset

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous, active-high reset
inst_field  input  32  current IR contents from datapath (valid from DECODE onward)
pc_in  input  32  current PC from datapath, captured on trap
zero  input  1  ALU zero flag
mem_ready  input  1  memory handshake: request accepted/data valid this cycle
mem_req  output  1  memory request (fetch or data)
mem_we  output  1  data write strobe, qualified by mem_req
mem_ifetch  output  1  1 = current request is an instruction fetch
IRWrite  output  1  latch fetched word into IR
PCWrite  output  1  commit next PC this cycle
ALU_Control  output  3  000 AND, 001 OR, 010 ADD, 011 XOR, 100 NOR, 101 SRL, 110 SUB, 111 SLT
ImmSel  output  2  00 I, 01 S, 10 B, 11 J
MemtoReg  output  2  00 ALU, 01 memory, 10 PC+4
ALUSrc_B  output  1  0 rs2, 1 immediate
Jump  output  1  select jump target for PC
Branch  output  1  branch qualifier (datapath takes target if zero)
RegWrite  output  1  register write enable
trap  output  1  sticky trap flag
trap_cause  output  2  00 none, 01 illegal instruction, 10 memory timeout
trap_pc  output  32  PC of trapping instruction
state_dbg  output  3  FETCH 0, DECODE 1, EXEC 2, MEM 3, WB 4, TRAP 5

Behaviour:
- Reset (rst=1 at clk edge): state<=FETCH, wait counter<=0, trap<=0, trap_cause<=00, trap_pc<=PC_RESET. All control strobes are 0 in any cycle where rst is high.
- Control outputs are combinational from registered state and inst_field; unlisted strobes are 0.
- FETCH: mem_req=1, mem_ifetch=1. Holds until mem_ready; in the mem_ready cycle IRWrite=1, next DECODE.
- DECODE: legal = R (0110011; f3/f7 in ADD, SUB, AND, OR, XOR, SRL, SLT), I-ALU (0010011; ADDI, ANDI, ORI, XORI, SLTI), LW (0000011, f3=010), SW (0100011, f3=010), BEQ (1100011, f3=000), JAL (1101111). Illegal -> TRAP (cause 01, trap_pc<=pc_in); else -> EXEC.
- EXEC:
  - R/I: ALU op from funct; I sets ALUSrc_B=1, ImmSel=00. Next WB.
  - LW/SW: ADD, ALUSrc_B=1, ImmSel 00/01. Next MEM.
  - BEQ: SUB, Branch=1, ImmSel=10, PCWrite=1. Next FETCH.
  - JAL: Jump=1, ImmSel=11, MemtoReg=10, RegWrite=(rd!=0), PCWrite=1. Next FETCH.
- MEM: mem_req=1, mem_we=(SW), ALU inputs held as in EXEC. On mem_ready: LW -> WB; SW asserts PCWrite=1 that cycle -> FETCH.
- WB: RegWrite=(rd!=0), MemtoReg=01 for LW else 00, PCWrite=1. Next FETCH.
- Wait counter: increments each cycle mem_req=1 and mem_ready=0; clears on mem_ready or state change. If WAIT_LIMIT!=0 and counter reaches WAIT_LIMIT -> TRAP (cause 10, trap_pc<=pc_in) with no strobes issued.
- TRAP: all strobes 0, remains until rst. trap, trap_cause and trap_pc hold.
- mem_ready outside FETCH/MEM is ignored.
- mem_ready on the first request cycle gives zero wait: ALU op takes 4 cycles, LW 5, SW 4, BEQ/JAL 3.
- rst mid-instruction aborts it with no PCWrite/RegWrite in the reset cycle; the next cycle is FETCH.

Optional Feature:
PERF_CNT_EN: when defined, adds outputs cycle_cnt[31:0] (increments every non-reset cycle, stops in TRAP) and instret_cnt[31:0] (increments on each PCWrite). Both wrap at 2^32 and clear on rst. When undefined, the ports and logic are absent.

Test Plan:
- ADD x3,x1,x2 with mem_ready tied 1 -> state sequence 0,1,2,4,0; RegWrite=1 only in WB; ALU_Control=010; PCWrite in WB only.
- LW x5,8(x1), mem_ready delayed 3 cycles in MEM -> mem_req held 4 cycles with mem_we=0; WB MemtoReg=01, RegWrite=1.
- BEQ with zero=1 then zero=0 -> Branch=1, ALU_Control=110, PCWrite=1 in EXEC both times; 3 cycles each.
- Instruction 32'hFFFF_FFFF at pc_in=0x40 -> TRAP after DECODE; trap=1, trap_cause=01, trap_pc=0x40; no strobes afterward.
- WAIT_LIMIT=16, mem_ready held 0 in FETCH -> trap_cause=10 after 16 cycles; rst then returns to FETCH with trap=0.
- JAL x0 -> RegWrite=0, Jump=1, PCWrite=1. With PERF_CNT_EN, instret_cnt increments by 1 per retired instruction.
